// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises configuration words onto one ccff
// chain segment, with an optional second pass that checks ccff_tail.
//
// Ports:
//   prog_clk, pReset   clock, synchronous active-high reset
//   start, verify      begin a pass (IDLE only); verify latched on start
//   cfg_data/valid/ready  word handshake, bit 0 of a word shifted first
//   ccff_head          serial data into the chain
//   ccff_clk_en        chain shifts on every prog_clk edge where this is 1
//   ccff_tail          serial data out of the chain
//   busy, done         not idle / one-cycle end-of-pass pulse
//   error, err_idx     sticky verify mismatch and first failing bit index
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 46,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_idx
);

  localparam int NB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [WORD_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [NB_W-1:0]   r_nbits;
  logic              r_verify;
  logic              r_error;
  logic [CNT_W-1:0]  r_err_idx;

  int                w_rem;
  logic [NB_W-1:0]   w_first_nbits;
  logic              w_last_bit;
  logic              w_chain_full;
  logic              w_mismatch;

  // Bits still owed to the chain; the final word may be partial.
  always_comb begin
    w_rem = CHAIN_LEN - int'(r_bit_cnt);
    if (w_rem >= WORD_W) begin
      w_first_nbits = NB_W'(WORD_W);
    end else begin
      w_first_nbits = NB_W'(w_rem);
    end
  end

  assign w_last_bit   = (r_nbits == NB_W'(1));
  // bit_cnt reaches CHAIN_LEN on this edge.
  assign w_chain_full = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  // Tail shows the previous pass's copy of the bit now on head.
  assign w_mismatch   = r_verify && (ccff_tail != r_shreg[0]);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    cfg_ready   = 1'b0;
    ccff_clk_en = 1'b0;
    ccff_head   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ccff_clk_en = 1'b1;
        ccff_head   = r_shreg[0];
        if (w_last_bit) begin
          w_next = w_chain_full ? S_DONE : S_WAIT;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_nbits   <= '0;
      r_verify  <= 1'b0;
      r_error   <= 1'b0;
      r_err_idx <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_verify  <= verify;
            r_error   <= 1'b0;
            r_err_idx <= '0;
            r_bit_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (cfg_valid) begin
            r_shreg <= cfg_data;
            r_nbits <= w_first_nbits;
          end
        end
        S_SHIFT: begin
          r_shreg   <= r_shreg >> 1;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          r_nbits   <= r_nbits - NB_W'(1);
          if (w_mismatch && !r_error) begin
            r_error   <= 1'b1;
            r_err_idx <= r_bit_cnt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign error   = r_error;
  assign err_idx = r_err_idx;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed table of load/verify passes against a
// 46-flop chain model, plus hand-written reset and idle sequences.
module tb_ccff_chain_loader;

  localparam int CL = 46;
  localparam int WW = 8;
  localparam int CW = 6;
  localparam logic [CL-1:0] STK10 = 46'd1 << 10;

  logic          clk = 1'b0;
  logic          pReset;
  logic          start;
  logic          verify;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          ccff_head;
  logic          ccff_clk_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] err_idx;

  always #5 clk = ~clk;

  ccff_chain_loader #(
    .CHAIN_LEN(CL),
    .WORD_W(WW)
  ) dut (
    .prog_clk(clk),
    .pReset(pReset),
    .start(start),
    .verify(verify),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .ccff_head(ccff_head),
    .ccff_clk_en(ccff_clk_en),
    .ccff_tail(ccff_tail),
    .busy(busy),
    .done(done),
    .error(error),
    .err_idx(err_idx)
  );

  // Chain model: head enters flop CL-1, tail is flop 0, so after a
  // full load flop k holds stream bit k.
  logic [CL-1:0] chain = '0;
  logic [CL-1:0] chain_eff;
  logic          stuck = 1'b0;

  assign chain_eff = chain | (stuck ? STK10 : '0);
  assign ccff_tail = chain_eff[0];

  always @(posedge clk) begin
    if (ccff_clk_en) begin
      chain <= {ccff_head, chain_eff[CL-1:1]};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CL-1:0] stream(input logic [5:0][7:0] w);
    logic [CL-1:0] s;
    s = '0;
    for (int k = 0; k < CL; k++) begin
      s[k] = w[k/8][k%8];
    end
    return s;
  endfunction

  typedef struct {
    logic            v;
    logic [5:0][7:0] w;
    int              stall_word;
    int              stall_len;
    logic            stk;
    int              idle_valid;
    int              start_at;
    logic            chk_chain;
    int              exp_done;
    logic            exp_err;
    int              exp_idx;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input int id, input vec_t t);
    int            cyc;
    int            widx;
    int            nclk;
    int            stall_cnt;
    int            done_cyc;
    logic [CL-1:0] hb;
    stuck = t.stk;
    cfg_valid = 1'b1;
    cfg_data  = 8'h5A;
    repeat (t.idle_valid) begin
      @(negedge clk);
      chk("idle_ready", cfg_ready, 0);
      chk("idle_busy", busy, 0);
    end
    @(negedge clk);
    start  = 1'b1;
    verify = t.v;
    @(negedge clk);
    start  = 1'b0;
    verify = 1'b0;
    cyc = 1;
    widx = 0;
    nclk = 0;
    stall_cnt = 0;
    done_cyc = -1;
    hb = '0;
    while (cyc < 150) begin
      start = (cyc == t.start_at);
      if (cfg_ready) begin
        if (widx == t.stall_word && stall_cnt < t.stall_len) begin
          cfg_valid = 1'b0;
          stall_cnt++;
          chk("stall_clk_en", ccff_clk_en, 0);
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = (widx < 6) ? t.w[widx] : 8'hEE;
          widx++;
        end
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = 8'hEE;
      end
      if (ccff_clk_en) begin
        if (nclk < CL) hb[nclk] = ccff_head;
        nclk++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    $display("vec %0d: done in cycle %0d", id, done_cyc);
    chk("done_cycle", 64'(done_cyc), 64'(t.exp_done));
    chk("clk_en_count", 64'(nclk), 64'(CL));
    chk("words_taken", 64'(widx), 64'd6);
    chk("stall_cycles", 64'(stall_cnt), 64'(t.stall_len));
    chk("head_seq", hb, stream(t.w));
    chk("error", error, t.exp_err);
    chk("err_idx", err_idx, 64'(t.exp_idx));
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_after", busy, 0);
    chk("error_hold", error, t.exp_err);
    chk("err_idx_hold", err_idx, 64'(t.exp_idx));
    if (t.chk_chain) chk("chain", chain, stream(t.w));
  endtask

  logic [5:0][7:0] W;
  logic [5:0][7:0] Z;

  initial begin
    W = {8'h2B, 8'h81, 8'h00, 8'hFF, 8'h3C, 8'hA5};
    Z = '0;
    tbl[0] = '{1'b0, W, -1, 0, 1'b0, 0, -1, 1'b1, 53, 1'b0, 0};
    tbl[1] = '{1'b1, W, -1, 0, 1'b0, 0, -1, 1'b1, 53, 1'b0, 0};
    tbl[2] = '{1'b0, Z, -1, 0, 1'b0, 0, -1, 1'b1, 53, 1'b0, 0};
    tbl[3] = '{1'b1, Z, -1, 0, 1'b1, 0, -1, 1'b0, 53, 1'b1, 10};
    tbl[4] = '{1'b0, W, 2, 5, 1'b0, 0, -1, 1'b1, 58, 1'b0, 0};
    tbl[5] = '{1'b1, W, -1, 0, 1'b0, 3, 20, 1'b1, 53, 1'b0, 0};

    pReset = 1'b1;
    start = 1'b0;
    verify = 1'b0;
    cfg_data = '0;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_clk_en", ccff_clk_en, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_error", error, 0);
    chk("rst_err_idx", err_idx, 0);
    pReset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(i, tbl[i]);
    end

    // Reset in cycle 20, while the third word is shifting.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 8'hC3;
    repeat (19) @(negedge clk);
    chk("mid_shift", ccff_clk_en, 1);
    pReset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_clk_en", ccff_clk_en, 0);
    chk("abort_ready", cfg_ready, 0);
    chk("abort_done", done, 0);
    pReset = 1'b0;
    cfg_valid = 1'b0;
    run_vec(6, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequencer that loads one configuration-chain (ccff) segment of the routing fabric, e.g. the 46-bit chain through a switch block's mux memories.
- Accepts configuration words from the bitstream fetch logic over a valid/ready handshake and serialises them onto ccff_head, one bit per enabled prog_clk edge.
- Optional verify pass: the identical bitstream is shifted a second time, and ccff_tail is compared against each bit driven, which detects chain breaks and stuck bits.

Parameters:
- CHAIN_LEN, 46: number of ccff flops in the chain; must be >= 1.
- WORD_W, 8: configuration word width; must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+1): bit-counter width, derived from CHAIN_LEN.

Ports:
- prog_clk  in  1  single clock for the block.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  begin a load/verify pass; sampled only in IDLE.
- verify  in  1  latched on start; 1 = verify pass (shift and compare).
- cfg_data  in  WORD_W  configuration word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  block accepts a word this cycle.
- ccff_head  out  1  serial data into the chain.
- ccff_clk_en  out  1  enable for the gated prog_clk of the chain; the chain shifts on every edge where this is 1.
- ccff_tail  in  1  serial data out of the chain.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a pass completes.
- error  out  1  sticky mismatch flag for the last verify pass.
- err_idx  out  CNT_W  bit index of the first mismatch.

Behaviour:
- Reset is synchronous: on a pReset edge the state goes to IDLE.
  - Reset values: cfg_ready=0, ccff_clk_en=0, ccff_head=0, busy=0, done=0, error=0, err_idx=0, bit_cnt=0.
  - Reset mid-pass aborts immediately. Chain contents are undefined afterwards and a full reload is required.
- States:
  - IDLE: on start=1, latch verify, clear error and err_idx, set bit_cnt=0, go to WAIT_WORD. start while busy is ignored.
  - WAIT_WORD: cfg_ready=1 (combinational from state). On cfg_valid & cfg_ready:
    - load shreg=cfg_data;
    - set nbits=min(WORD_W, CHAIN_LEN-bit_cnt);
    - go to SHIFT.
  - SHIFT: ccff_clk_en=1 and ccff_head=shreg[0] every cycle. At the edge: shreg>>=1, bit_cnt+=1, nbits-=1. When nbits reaches 0:
    - if bit_cnt==CHAIN_LEN, go to DONE;
    - otherwise go to WAIT_WORD.
  - DONE: done=1 for exactly one cycle, then IDLE. error and err_idx hold until the next start or reset.
- Words are never accepted in SHIFT, DONE or IDLE.
- Last-word rule: if CHAIN_LEN is not a multiple of WORD_W, only the low (CHAIN_LEN mod WORD_W) bits of the final word are shifted; its upper bits are discarded.
- Word count per pass is ceil(CHAIN_LEN/WORD_W): 6 words for the defaults.
- Verify compare:
  - Applies in every SHIFT cycle with latched verify=1.
  - The comparison is ccff_tail (the value before the edge) against ccff_head. During the second pass, tail presents bit j of the previous pass exactly when bit j is being driven again.
  - On the first mismatch: error<=1 and err_idx<=bit_cnt. Later mismatches do not update err_idx.
  - With verify=0, no compare is made and error stays 0.
- Latency: with cfg_valid held high, the state is WAIT_WORD in cycle 1 after the start edge. Each full word takes 1 accept cycle + WORD_W shift cycles.
  - Defaults: the last shift is in cycle 52 and done=1 in cycle 53.
- Deasserting cfg_valid in WAIT_WORD stalls indefinitely. ccff_clk_en stays 0 during the stall, so chain state is preserved.

Test Plan:
- Load, defaults, verify=0, words 0xA5,0x3C,0xFF,0x00,0x81,0x2B, valid held high -> exactly 46 ccff_clk_en cycles, ccff_head sequence is LSB-first per word, word 6 contributes only bits [5:0]=0x2B, done pulses in cycle 53, error=0.
- Chain model (46-flop shift register) loaded, then verify=1 with the same 6 words -> error=0, done in cycle 53, final chain state equals the first load.
- Verify with model flop 10 stuck-at-1 and all-zero words -> error=1, err_idx=10.
- Stall: cfg_valid low for 5 cycles before word 3 -> cfg_ready=1 and ccff_clk_en=0 throughout the stall, done delayed to cycle 58, same head sequence.
- pReset asserted in cycle 20 (mid-SHIFT) -> next cycle busy=0, ccff_clk_en=0, cfg_ready=0; a subsequent start runs a clean 53-cycle pass.
- start pulsed during SHIFT, and cfg_valid high in IDLE -> both ignored, no extra words consumed, bit count unchanged.
